// File: rtl/top_mult.sv
// Registered signed constant multiplier: out = inp * COEFF, exact, one cycle of latency.
// The product is built as a shift-add tree selected from COEFF's bits at elaboration.
module top_mult #(
  parameter int BIT_WIDTH  = 6,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = BIT_WIDTH + COEF_WIDTH,
  parameter logic signed [COEF_WIDTH-1:0] COEFF = 8'sd93
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [BIT_WIDTH-1:0] inp,
  output logic signed [OUT_WIDTH-1:0] out
);

  localparam logic signed [COEF_WIDTH-1:0] Coef = COEFF;

  logic signed [OUT_WIDTH-1:0] inpExt;
  logic signed [OUT_WIDTH-1:0] partProd [COEF_WIDTH];
  logic signed [OUT_WIDTH-1:0] out_d;
  logic signed [OUT_WIDTH-1:0] out_q;

  assign inpExt = OUT_WIDTH'(inp);

  // Coefficient MSB carries negative weight in two's complement, so it subtracts.
  for (genvar g = 0; g < COEF_WIDTH; g++) begin : gPartProd
    if (!Coef[g]) begin : gZero
      assign partProd[g] = '0;
    end else if (g == COEF_WIDTH - 1) begin : gSign
      assign partProd[g] = -(inpExt <<< g);
    end else begin : gPos
      assign partProd[g] = inpExt <<< g;
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < COEF_WIDTH; i++) begin
      out_d = out_d + partProd[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_top_mult.sv
// Self-checking bench for top_mult: directed table, exhaustive sweep, coefficient corners,
// asynchronous reset behaviour and a randomised stream with reset pulses.
module tb_top_mult;

  logic              clk;
  logic              rst_n;
  logic signed [5:0] inp;
  logic signed [13:0] out93, outNeg128, out127, out0;

  int compared;
  int mismatched;

  top_mult #(.COEFF(8'sd93)) dut93 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .out(out93));
  top_mult #(.COEFF(-8'sd128)) dutNeg128 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .out(outNeg128));
  top_mult #(.COEFF(8'sd127)) dut127 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .out(out127));
  top_mult #(.COEFF(8'sd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .out(out0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [5:0] inp;
    int e93;
    int eNeg128;
    int e127;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive a sample and advance to 1 time unit past the capturing edge.
  task automatic applyStimulus(input logic signed [5:0] v);
    inp = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string name, input int v);
    checkOutput({name, "_c93"}, int'(out93), v * 93);
    checkOutput({name, "_cNeg128"}, int'(outNeg128), v * -128);
    checkOutput({name, "_c127"}, int'(out127), v * 127);
    checkOutput({name, "_c0"}, int'(out0), 0);
  endtask

  initial begin
    int v;
    int prev;
    compared   = 0;
    mismatched = 0;

    vecs[0] = '{inp: 6'sd0,  e93: 0,     eNeg128: 0,     e127: 0};
    vecs[1] = '{inp: 6'sd1,  e93: 93,    eNeg128: -128,  e127: 127};
    vecs[2] = '{inp: -6'sd1, e93: -93,   eNeg128: 128,   e127: -127};
    vecs[3] = '{inp: 6'sd31, e93: 2883,  eNeg128: -3968, e127: 3937};
    vecs[4] = '{inp: -6'sd32, e93: -2976, eNeg128: 4096, e127: -4064};
    vecs[5] = '{inp: 6'sd5,  e93: 465,   eNeg128: -640,  e127: 635};

    // Reset held low while clocking with a nonzero input.
    rst_n = 1'b0;
    inp   = 6'sd31;
    #1;
    checkOutput("reset_initial", int'(out93), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_held", int'(out93), 0);
    end

    // Release mid-cycle; the first edge captures the current input.
    rst_n = 1'b1;
    applyStimulus(6'sd31);
    checkOutput("release_capture", int'(out93), 2883);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].inp);
      checkOutput($sformatf("vec%0d_c93", i), int'(out93), vecs[i].e93);
      checkOutput($sformatf("vec%0d_cNeg128", i), int'(outNeg128), vecs[i].eNeg128);
      checkOutput($sformatf("vec%0d_c127", i), int'(out127), vecs[i].e127);
      checkOutput($sformatf("vec%0d_c0", i), int'(out0), 0);
    end

    // Output must not change before the next edge even when inp does.
    applyStimulus(-6'sd1);
    inp = 6'sd31;
    #3;
    checkOutput("latency_hold", int'(out93), -93);
    @(posedge clk);
    #1;
    checkOutput("latency_next", int'(out93), 2883);

    // Asynchronous reset mid-cycle clears the output before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", int'(out93), 0);
    checkOutput("async_clear_neg", int'(outNeg128), 0);
    @(posedge clk);
    #1;
    checkOutput("async_held", int'(out93), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("async_after_release", int'(out93), 0);

    // Exhaustive sweep back-to-back, one sample per cycle.
    for (int k = 0; k < 64; k++) begin
      v = k - 32;
      applyStimulus(6'(v));
      checkAll($sformatf("sweep%0d", v), v);
    end

    // Random stream with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rand_rst_during", int'(out93), 0);
        @(posedge clk);
        #1;
        checkOutput("rand_rst_edge", int'(out93), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rand_rst_after", int'(out93), 0);
        checkOutput("rand_rst_after_127", int'(out127), 0);
      end
      prev = int'($signed(6'($urandom_range(0, 63))));
      applyStimulus(6'(prev));
      checkAll("rand", prev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
